// File: rtl/pd_tx_pkg.sv
// Shared types and constants for the PD transmit scheduler.
// Optional build macro: PD_TX_WATCHDOG_EN (see pd_tx_scheduler).
package pd_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_GCRC,
    SRC_HR,
    SRC_PE
  } src_t;

  localparam logic [2:0] SOP_T      = 3'd0;
  localparam logic [2:0] SOP_P      = 3'd1;
  localparam logic [2:0] SOP_PP     = 3'd2;
  localparam logic [2:0] HARD_RESET = 3'd5;

  localparam logic [1:0] ST_SUCCESS   = 2'b00;
  localparam logic [1:0] ST_FAILED    = 2'b01;
  localparam logic [1:0] ST_DISCARDED = 2'b10;
  localparam logic [1:0] ST_TIMEOUT   = 2'b11;

  localparam logic [1:0] RETRY_CNT = 2'b11;
  localparam int         MSGID_LSB = 1;

  function automatic logic [7:0] stamp_msgid(
    input logic [7:0] hdr,
    input logic [2:0] id
  );
    logic [7:0] h;
    h = hdr;
    h[MSGID_LSB +: 3] = id;
    return h;
  endfunction

endpackage

// File: rtl/pd_msgid_counters.sv
// Per-SOP MessageID counters (SOP, SOP', SOP'').
// Increment one counter by SOP index, or clear all three.
module pd_msgid_counters
  import pd_tx_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic       inc,
  input  logic [1:0] inc_sop,
  input  logic       clear_all,
  input  logic [1:0] sel,
  output logic [2:0] sel_id
);

  logic [2:0] cnt_t;
  logic [2:0] cnt_p;
  logic [2:0] cnt_pp;

  always_ff @(posedge CLK) begin
    if (reset || clear_all) begin
      cnt_t  <= '0;
      cnt_p  <= '0;
      cnt_pp <= '0;
    end else if (inc) begin
      case (inc_sop)
        SOP_T[1:0]:  cnt_t  <= cnt_t + 3'd1;
        SOP_P[1:0]:  cnt_p  <= cnt_p + 3'd1;
        SOP_PP[1:0]: cnt_pp <= cnt_pp + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_id = '0;
    case (sel)
      SOP_T[1:0]:  sel_id = cnt_t;
      SOP_P[1:0]:  sel_id = cnt_p;
      SOP_PP[1:0]: sel_id = cnt_pp;
      default:     sel_id = '0;
    endcase
  end

endmodule

// File: rtl/pd_tx_scheduler.sv
// Fixed-priority arbiter/sequencer in front of PRL Tx.
// Define PD_TX_WATCHDOG_EN to enable the WAIT-state timeout.
module pd_tx_scheduler
  import pd_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        gcrc_req,
  input  logic [2:0]  gcrc_sop,
  input  logic [2:0]  gcrc_msgid,
  output logic        gcrc_ack,
  input  logic        hr_req,
  output logic        hr_ack,
  output logic        hr_done,
  input  logic        pe_req,
  input  logic [2:0]  pe_sop,
  input  logic [7:0]  pe_byte_count,
  input  logic [7:0]  pe_header_low,
  input  logic [7:0]  pe_header_high,
  output logic        pe_ack,
  output logic        pe_done,
  output logic [1:0]  pe_status,
  input  logic        rx_busy,
  output logic [15:0] TRANSMIT,
  output logic [7:0]  TRANSMIT_BYTE_COUNT,
  output logic [7:0]  TRANSMIT_HEADER_LOW,
  output logic [7:0]  TRANSMIT_HEADER_HIGH,
  output logic [7:0]  TX_BUF_HEADER_BYTE_1,
  output logic        tx_start,
  input  logic        tx_success,
  input  logic        tx_failed,
  input  logic        tx_discarded
);

  state_t     state, state_nx;
  src_t       src;
  logic       pe_bad;
  logic [1:0] status;
  logic [1:0] outc_status;
  logic [2:0] pe_id;
  logic       grant_g, grant_h, grant_p, any_grant;
  logic       outcome, tmo;
  logic       id_inc, id_clr;

  assign grant_g   = gcrc_req;
  assign grant_h   = !gcrc_req && hr_req;
  assign grant_p   = !gcrc_req && !hr_req && pe_req && !rx_busy;
  assign any_grant = grant_g || grant_h || grant_p;
  assign outcome   = tx_failed || tx_discarded || tx_success;

  always_comb begin
    outc_status = ST_SUCCESS;
    if (tx_failed)         outc_status = ST_FAILED;
    else if (tx_discarded) outc_status = ST_DISCARDED;
  end

  assign id_inc = (state == S_DONE) && (src == SRC_PE) &&
                  (status == ST_SUCCESS) && !pe_bad;
  assign id_clr = (state == S_DONE) && (src == SRC_HR);

  pd_msgid_counters u_ids (
    .CLK       (CLK),
    .reset     (reset),
    .inc       (id_inc),
    .inc_sop   (TRANSMIT[1:0]),
    .clear_all (id_clr),
    .sel       (pe_sop[1:0]),
    .sel_id    (pe_id)
  );

`ifdef PD_TX_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  logic [WDW-1:0] wdog;

  always_ff @(posedge CLK) begin
    if (reset || state != S_WAIT) wdog <= '0;
    else                          wdog <= wdog + 1'b1;
  end

  assign tmo = (state == S_WAIT) &&
               (wdog == WDW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gcrc_ack = 1'b0;
    hr_ack   = 1'b0;
    pe_ack   = 1'b0;
    hr_done  = 1'b0;
    pe_done  = 1'b0;
    tx_start = 1'b0;
    unique case (state)
      S_IDLE:  if (any_grant) state_nx = S_LOAD;
      S_LOAD: begin
        gcrc_ack = (src == SRC_GCRC);
        hr_ack   = (src == SRC_HR);
        pe_ack   = (src == SRC_PE);
        state_nx = pe_bad ? S_DONE : S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT:  if (outcome || tmo) state_nx = S_DONE;
      S_DONE: begin
        hr_done  = (src == SRC_HR);
        pe_done  = (src == SRC_PE);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state                <= S_IDLE;
      src                  <= SRC_GCRC;
      pe_bad               <= 1'b0;
      status               <= ST_SUCCESS;
      TRANSMIT             <= '0;
      TRANSMIT_BYTE_COUNT  <= '0;
      TRANSMIT_HEADER_LOW  <= '0;
      TRANSMIT_HEADER_HIGH <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && any_grant) begin
        unique case (1'b1)
          grant_g: begin
            src                  <= SRC_GCRC;
            pe_bad               <= 1'b0;
            TRANSMIT             <= {13'd0, gcrc_sop};
            TRANSMIT_BYTE_COUNT  <= 8'd2;
            TRANSMIT_HEADER_LOW  <= 8'd0;
            TRANSMIT_HEADER_HIGH <= stamp_msgid(8'd0, gcrc_msgid);
          end
          grant_h: begin
            src                  <= SRC_HR;
            pe_bad               <= 1'b0;
            TRANSMIT             <= {13'd0, HARD_RESET};
            TRANSMIT_BYTE_COUNT  <= 8'd0;
            TRANSMIT_HEADER_LOW  <= 8'd0;
            TRANSMIT_HEADER_HIGH <= 8'd0;
          end
          grant_p: begin
            src                  <= SRC_PE;
            pe_bad               <= (pe_sop > SOP_PP);
            TRANSMIT             <= {10'd0, RETRY_CNT, 1'b0, pe_sop};
            TRANSMIT_BYTE_COUNT  <= pe_byte_count;
            TRANSMIT_HEADER_LOW  <= pe_header_low;
            TRANSMIT_HEADER_HIGH <= stamp_msgid(pe_header_high, pe_id);
          end
          default: ;
        endcase
      end
      if (state == S_LOAD && pe_bad) status <= ST_FAILED;
      if (state == S_WAIT) begin
        if (outcome)  status <= outc_status;
        else if (tmo) status <= ST_TIMEOUT;
      end
    end
  end

  assign pe_status            = status;
  assign TX_BUF_HEADER_BYTE_1 = TRANSMIT_HEADER_HIGH;

endmodule

// File: tb/tb_pd_tx_scheduler.sv
// Scoreboard bench for pd_tx_scheduler: grant order, register image,
// status, MessageID stamping/wrap/clear, invalid SOP, reset, watchdog.
module tb_pd_tx_scheduler;

`ifdef PD_TX_WATCHDOG_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        gcrc_req = 1'b0;
  logic [2:0]  gcrc_sop = '0;
  logic [2:0]  gcrc_msgid = '0;
  logic        gcrc_ack;
  logic        hr_req = 1'b0;
  logic        hr_ack, hr_done;
  logic        pe_req = 1'b0;
  logic [2:0]  pe_sop = '0;
  logic [7:0]  pe_byte_count = '0;
  logic [7:0]  pe_header_low = '0;
  logic [7:0]  pe_header_high = '0;
  logic        pe_ack, pe_done;
  logic [1:0]  pe_status;
  logic        rx_busy = 1'b0;
  logic [15:0] TRANSMIT;
  logic [7:0]  TRANSMIT_BYTE_COUNT, TRANSMIT_HEADER_LOW;
  logic [7:0]  TRANSMIT_HEADER_HIGH, TX_BUF_HEADER_BYTE_1;
  logic        tx_start;
  logic        tx_success = 1'b0;
  logic        tx_failed = 1'b0;
  logic        tx_discarded = 1'b0;

  pd_tx_scheduler #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .CLK(CLK), .reset(reset),
    .gcrc_req(gcrc_req), .gcrc_sop(gcrc_sop),
    .gcrc_msgid(gcrc_msgid), .gcrc_ack(gcrc_ack),
    .hr_req(hr_req), .hr_ack(hr_ack), .hr_done(hr_done),
    .pe_req(pe_req), .pe_sop(pe_sop),
    .pe_byte_count(pe_byte_count),
    .pe_header_low(pe_header_low),
    .pe_header_high(pe_header_high),
    .pe_ack(pe_ack), .pe_done(pe_done), .pe_status(pe_status),
    .rx_busy(rx_busy), .TRANSMIT(TRANSMIT),
    .TRANSMIT_BYTE_COUNT(TRANSMIT_BYTE_COUNT),
    .TRANSMIT_HEADER_LOW(TRANSMIT_HEADER_LOW),
    .TRANSMIT_HEADER_HIGH(TRANSMIT_HEADER_HIGH),
    .TX_BUF_HEADER_BYTE_1(TX_BUF_HEADER_BYTE_1),
    .tx_start(tx_start), .tx_success(tx_success),
    .tx_failed(tx_failed), .tx_discarded(tx_discarded)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] t;
    logic [7:0]  bc;
    logic [7:0]  hl;
    logic [7:0]  hh;
  } img_t;

  img_t       exp_img_q[$];
  logic [1:0] exp_st_q[$];
  int         exp_ack_q[$];
  logic [2:0] mid[3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int st_cnt = 0;
  int done_cnt = 0;
  int mon_code;
  img_t mon_img;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return gcrc_ack;
      1: return hr_ack;
      2: return pe_ack;
      3: return tx_start;
      4: return pe_done;
      default: return hr_done;
    endcase
  endfunction

  always @(negedge CLK) if (!reset) begin
    if (gcrc_ack || hr_ack || pe_ack) begin
      ack_cnt++;
      case ({gcrc_ack, hr_ack, pe_ack})
        3'b100:  mon_code = 0;
        3'b010:  mon_code = 1;
        3'b001:  mon_code = 2;
        default: mon_code = 9;
      endcase
      if (exp_ack_q.size() == 0) check_eq("ack_unexp", mon_code, 99);
      else check_eq("ack_order", mon_code, exp_ack_q.pop_front());
    end
    if (tx_start) begin
      st_cnt++;
      if (exp_img_q.size() == 0) check_eq("start_unexp", 1, 0);
      else begin
        mon_img = exp_img_q.pop_front();
        check_eq("transmit", TRANSMIT, mon_img.t);
        check_eq("byte_cnt", TRANSMIT_BYTE_COUNT, mon_img.bc);
        check_eq("hdr_low", TRANSMIT_HEADER_LOW, mon_img.hl);
        check_eq("hdr_high", TRANSMIT_HEADER_HIGH, mon_img.hh);
        check_eq("txbuf_b1", TX_BUF_HEADER_BYTE_1, mon_img.hh);
      end
    end
    if (pe_done) begin
      done_cnt++;
      if (exp_st_q.size() == 0) check_eq("done_unexp", 1, 0);
      else check_eq("pe_status", pe_status, exp_st_q.pop_front());
    end
  end

  task automatic wait_sig(input int s, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!sig(s) && n < 200);
    if (!sig(s)) check_eq({tag, "_tmo"}, 0, 1);
  endtask

  task automatic push_pe(input logic [2:0] sop, input logic [7:0] hl,
                         input logic [7:0] hh, input logic [7:0] bc,
                         input int kind);
    img_t e;
    logic [7:0] h;
    exp_ack_q.push_back(2);
    if (sop < 3) begin
      h = hh;
      h[3:1] = mid[sop[1:0]];
      e.t = {10'd0, 2'b11, 1'b0, sop};
      e.bc = bc;
      e.hl = hl;
      e.hh = h;
      exp_img_q.push_back(e);
      case (kind)
        0: begin
          exp_st_q.push_back(2'b00);
          mid[sop[1:0]] = mid[sop[1:0]] + 3'd1;
        end
        1, 3:    exp_st_q.push_back(2'b01);
        2:       exp_st_q.push_back(2'b10);
        default: exp_st_q.push_back(2'b11);
      endcase
    end else exp_st_q.push_back(2'b01);
  endtask

  task automatic do_outcome(input int kind, input int dsel,
                            input int acyc);
    wait_sig(3, "tx_start");
    check_eq("start_lat", cyc - acyc, 1);
    @(negedge CLK);
    tx_failed    = (kind == 1 || kind == 3);
    tx_discarded = (kind == 2);
    tx_success   = (kind == 0 || kind == 3);
    @(negedge CLK);
    tx_failed = 0; tx_discarded = 0; tx_success = 0;
    if (dsel >= 0) check_eq("done_lat", sig(dsel), 1);
  endtask

  task automatic drive_pe(input logic [2:0] sop, input logic [7:0] hl,
                          input logic [7:0] hh, input logic [7:0] bc);
    pe_sop = sop; pe_header_low = hl;
    pe_header_high = hh; pe_byte_count = bc;
  endtask

  task automatic pe_txn(input logic [2:0] sop, input logic [7:0] hl,
                        input logic [7:0] hh, input logic [7:0] bc,
                        input int kind);
    int t0;
    push_pe(sop, hl, hh, bc, kind);
    @(negedge CLK);
    drive_pe(sop, hl, hh, bc);
    pe_req = 1; t0 = cyc;
    wait_sig(2, "pe_ack");
    pe_req = 0;
    check_eq("ack_lat", cyc - t0, 1);
    if (sop < 3) do_outcome(kind, 4, cyc);
    else wait_sig(4, "bad_done");
  endtask

  initial begin
    int s0, c0;
    img_t e;
    for (int i = 0; i < 3; i++) mid[i] = 3'd0;
    repeat (3) @(negedge CLK);
    check_eq("reset_outs", {gcrc_ack, hr_ack, hr_done, pe_ack, pe_done,
             pe_status, TRANSMIT, TRANSMIT_BYTE_COUNT, TRANSMIT_HEADER_LOW,
             TRANSMIT_HEADER_HIGH, TX_BUF_HEADER_BYTE_1, tx_start}, 0);
    reset = 0;

    pe_txn(3'd0, 8'h11, 8'hFF, 8'h1E, 0);
    pe_txn(3'd0, 8'h22, 8'hFF, 8'h04, 0);
    pe_txn(3'd2, 8'h33, 8'h00, 8'h06, 2);
    pe_txn(3'd0, 8'h44, 8'h0E, 8'h02, 3);
    pe_txn(3'd0, 8'h55, 8'hA5, 8'h08, 0);

    exp_ack_q.push_back(0);
    exp_ack_q.push_back(1);
    e = '{t: 16'h0002, bc: 8'd2, hl: 8'h00, hh: 8'h06};
    exp_img_q.push_back(e);
    e = '{t: 16'h0005, bc: 8'd0, hl: 8'h00, hh: 8'h00};
    exp_img_q.push_back(e);
    for (int i = 0; i < 3; i++) mid[i] = 3'd0;
    push_pe(3'd0, 8'h66, 8'hFF, 8'h0A, 0);
    @(negedge CLK);
    gcrc_sop = 3'd2; gcrc_msgid = 3'd3;
    drive_pe(3'd0, 8'h66, 8'hFF, 8'h0A);
    gcrc_req = 1; hr_req = 1; pe_req = 1;
    wait_sig(0, "gcrc_ack");
    gcrc_req = 0;
    do_outcome(0, -1, cyc);
    wait_sig(1, "hr_ack");
    hr_req = 0;
    do_outcome(1, 5, cyc);
    wait_sig(2, "pe_ack");
    pe_req = 0;
    do_outcome(0, 4, cyc);

    exp_ack_q.push_back(0);
    e = '{t: 16'h0001, bc: 8'd2, hl: 8'h00, hh: 8'h0A};
    exp_img_q.push_back(e);
    @(negedge CLK);
    gcrc_sop = 3'd1; gcrc_msgid = 3'd5; gcrc_req = 1;
    wait_sig(0, "gcrc_ack2");
    gcrc_req = 0;
    do_outcome(2, -1, cyc);

    for (int i = 0; i < 9; i++) pe_txn(3'd1, 8'h77, 8'h00, 8'h02, 0);

    @(negedge CLK);
    rx_busy = 1;
    drive_pe(3'd2, 8'h88, 8'hF0, 8'h02);
    pe_req = 1; c0 = ack_cnt;
    repeat (6) @(negedge CLK);
    check_eq("rx_block", ack_cnt - c0, 0);
    push_pe(3'd2, 8'h88, 8'hF0, 8'h02, 0);
    rx_busy = 0;
    wait_sig(2, "pe_ack_rx");
    pe_req = 0;
    do_outcome(0, 4, cyc);

    s0 = st_cnt;
    pe_txn(3'd4, 8'h99, 8'h00, 8'h02, 0);
    check_eq("bad_no_start", st_cnt - s0, 0);

`ifdef PD_TX_WATCHDOG_EN
    push_pe(3'd2, 8'hAA, 8'h00, 8'h02, 4);
    @(negedge CLK);
    drive_pe(3'd2, 8'hAA, 8'h00, 8'h02);
    pe_req = 1;
    wait_sig(2, "pe_ack_wd");
    pe_req = 0;
    wait_sig(3, "start_wd");
    s0 = cyc;
    wait_sig(4, "wd_done");
    check_eq("wd_lat", cyc - (s0 + 1), 16);
`else
    push_pe(3'd2, 8'hAA, 8'h00, 8'h02, 0);
    @(negedge CLK);
    drive_pe(3'd2, 8'hAA, 8'h00, 8'h02);
    pe_req = 1;
    wait_sig(2, "pe_ack_wd");
    pe_req = 0;
    wait_sig(3, "start_wd");
    c0 = done_cnt;
    repeat (40) @(negedge CLK);
    check_eq("no_timeout", done_cnt - c0, 0);
    tx_success = 1;
    @(negedge CLK);
    tx_success = 0;
    check_eq("late_done", pe_done, 1);
`endif

    push_pe(3'd1, 8'hBB, 8'h00, 8'h02, 0);
    @(negedge CLK);
    drive_pe(3'd1, 8'hBB, 8'h00, 8'h02);
    pe_req = 1;
    wait_sig(2, "pe_ack_rst");
    pe_req = 0;
    wait_sig(3, "start_rst");
    @(negedge CLK);
    reset = 1;
    @(negedge CLK);
    check_eq("rst_mid_outs", {gcrc_ack, hr_ack, hr_done, pe_ack, pe_done,
             pe_status, TRANSMIT, TRANSMIT_BYTE_COUNT, TRANSMIT_HEADER_LOW,
             TRANSMIT_HEADER_HIGH, TX_BUF_HEADER_BYTE_1, tx_start}, 0);
    exp_img_q.delete();
    exp_st_q.delete();
    exp_ack_q.delete();
    for (int i = 0; i < 3; i++) mid[i] = 3'd0;
    reset = 0;
    c0 = done_cnt;
    repeat (5) @(negedge CLK);
    check_eq("rst_no_done", done_cnt - c0, 0);

    pe_txn(3'd1, 8'hCC, 8'h5A, 8'h02, 0);
    repeat (4) @(negedge CLK);
    check_eq("q_drained", exp_img_q.size() + exp_st_q.size()
             + exp_ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
